// File: rtl/state_step_driver.sv
// Push-button front end for the state register: synchronizes and debounces up/down buttons,
// then emits single-cycle step strobes with hold-to-auto-repeat and a tracked wrap-around state.
module state_step_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16,
  parameter int unsigned STATE_MAX       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       UpState,
  output logic       DownState,
  output logic [2:0] state,
  output logic       busy
);

  localparam int unsigned MaxA     = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_DELAY;
  localparam int unsigned MaxParam = (MaxA > REPEAT_PERIOD) ? MaxA : REPEAT_PERIOD;
  localparam int unsigned CntW     = $clog2(MaxParam) + 1;

  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_PERIOD - 1);
  localparam logic [2:0]      StMax    = 3'(STATE_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StHold,
    StRepeat,
    StDebRelease
  } fsm_e;

  fsm_e            fsm_q;
  logic            dir_up_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      up_sync_q;
  logic [1:0]      down_sync_q;

  logic up_s, down_s, req_up, req_down, req_match, step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_sync_q   <= 2'b00;
      down_sync_q <= 2'b00;
    end else begin
      up_sync_q   <= {up_sync_q[0], btn_up};
      down_sync_q <= {down_sync_q[0], btn_down};
    end
  end

  // Both buttons together decode as no request.
  always_comb begin
    up_s      = up_sync_q[1];
    down_s    = down_sync_q[1];
    req_up    = up_s & ~down_s;
    req_down  = down_s & ~up_s;
    req_match = dir_up_q ? req_up : req_down;
  end

  // A step fires on the terminal count of any pressing phase while the request persists.
  always_comb begin
    step = 1'b0;
    if (req_match) begin
      case (fsm_q)
        StDebPress: step = (cnt_q == DebLast);
        StHold:     step = (cnt_q == HoldLast);
        StRepeat:   step = (cnt_q == RepLast);
        default:    step = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= StIdle;
      dir_up_q  <= 1'b0;
      cnt_q     <= '0;
      UpState   <= 1'b0;
      DownState <= 1'b0;
      state     <= 3'd0;
    end else begin
      UpState   <= step & dir_up_q;
      DownState <= step & ~dir_up_q;
      if (step) begin
        if (dir_up_q) state <= (state == StMax) ? 3'd0 : state + 3'd1;
        else          state <= (state == 3'd0) ? StMax : state - 3'd1;
      end

      case (fsm_q)
        StIdle: begin
          cnt_q <= '0;
          if (req_up || req_down) begin
            dir_up_q <= req_up;
            fsm_q    <= StDebPress;
          end
        end
        StDebPress: begin
          if (!req_match) begin
            fsm_q <= StIdle;
            cnt_q <= '0;
          end else if (step) begin
            fsm_q <= StHold;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (!req_match) begin
            fsm_q <= StDebRelease;
            cnt_q <= '0;
          end else if (step) begin
            fsm_q <= StRepeat;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (!req_match) begin
            fsm_q <= StDebRelease;
            cnt_q <= '0;
          end else if (step) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDebRelease: begin
          // Any activity restarts the quiet-time count.
          if (up_s || down_s) begin
            cnt_q <= '0;
          end else if (cnt_q == DebLast) begin
            fsm_q <= StIdle;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          fsm_q <= StIdle;
          cnt_q <= '0;
        end
      endcase
    end
  end

  always_comb busy = (fsm_q != StIdle);

endmodule

// File: doc/state_step_driver.md
Name: state_step_driver

Overview:
- Command source for the FSM state register: turns two raw push-buttons (up/down) into clean single-cycle UpState/DownState strobes and a tracked 3-bit state value.
- Sits between the board buttons and Registro_states.
- Includes a two-flop synchronizer, a debounce filter and a hold-to-auto-repeat state machine, so one press gives exactly one step and a long hold steps at a fixed rate.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to accept a press or release (min 2).
- REPEAT_DELAY, 64, cycles after the first step before auto-repeat starts (min 2).
- REPEAT_PERIOD, 16, cycles between auto-repeat steps (min 2).
- STATE_MAX, 7, highest legal state value; wrap point (0..7).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- btn_up  input  1  raw up button, asynchronous, active-high
- btn_down  input  1  raw down button, asynchronous, active-high
- UpState  output  1  one-cycle step-up strobe to the state register
- DownState  output  1  one-cycle step-down strobe to the state register
- state  output  3  tracked state value after the latest strobe
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-low.
  - While rst=0: UpState=0, DownState=0, state=0, busy=0, FSM=IDLE, all counters=0, synchronizer flops=0.
- Synchronizer: each button passes through 2 flops, giving up_s and down_s. Only up_s/down_s are used downstream.
- Request decode:
  - req = UP when up_s=1 and down_s=0.
  - req = DOWN when down_s=1 and up_s=0.
  - req = NONE otherwise; both buttons pressed counts as NONE.
- FSM states and transitions:
  - IDLE: cnt=0. If req≠NONE, latch dir=req and go to DEB_PRESS.
  - DEB_PRESS: cnt increments each cycle while req==dir. If req≠dir, return to IDLE (glitch rejected, no strobe). When cnt reaches DEBOUNCE_CYCLES-1 with req==dir, go to HOLD and issue a step on that transition.
  - HOLD: cnt counts up to REPEAT_DELAY-1. If req≠dir, go to DEB_RELEASE. At the terminal count, go to REPEAT and issue a step.
  - REPEAT: cnt counts up to REPEAT_PERIOD-1, then issues a step and reloads cnt. If req≠dir, go to DEB_RELEASE.
  - DEB_RELEASE: cnt counts cycles with up_s=0 and down_s=0. Any button activity resets cnt to 0. At DEBOUNCE_CYCLES-1, go to IDLE. No strobes are issued in this state.
- Step action (registered; takes effect on the same edge as the FSM transition):
  - dir=UP: UpState=1 for exactly one cycle; state = (state==STATE_MAX) ? 0 : state+1.
  - dir=DOWN: DownState=1 for exactly one cycle; state = (state==0) ? STATE_MAX : state-1.
  - UpState and DownState are never high in the same cycle. Both are 0 in every cycle without a step.
- Latency: with a button held clean from edge E, the first strobe is high in the cycle after edge E+2+DEBOUNCE_CYCLES.
  - Subsequent strobes follow at +REPEAT_DELAY, then every +REPEAT_PERIOD cycles.
- Direction changes mid-hold:
  - Releasing one button and pressing the other goes through DEB_RELEASE first, so there is no immediate opposite step.
  - Pressing the second button while holding the first makes req=NONE, which ends the repeat (enter DEB_RELEASE).
- Reset mid-operation: any strobe in flight is dropped immediately and state returns to 0.
- Counters: width is $clog2 of the largest parameter + 1. Counters never wrap past their terminal count.
- busy = (FSM≠IDLE); it is combinational from the state register only.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, STATE_MAX=7):
1. Reset, then hold btn_up for 10 cycles and release → exactly one UpState pulse, first high in cycle 7 after the press edge; state 0→1; busy returns to 0 after release debounce.
2. Press btn_down from state=0 for 10 cycles → one DownState pulse; state=7 (wrap down). Repeat with state=7 and btn_up → state=0 (wrap up).
3. 2-cycle btn_up glitches repeated 5 times with 3-cycle gaps → no UpState or DownState; state unchanged; FSM back in IDLE.
4. Hold btn_up for 40 cycles from state=2 → strobes at cycles 7, 15, 19, 23, 27, …; state increments by one per strobe and wraps 7→0; never two strobes within 4 cycles.
5. Hold btn_up, then assert btn_down as well → repeat stops, no DownState. Release both, wait, press btn_down alone → one DownState after full debounce.
6. Pull rst low while busy in REPEAT with state=5 → outputs 0 and state=0 immediately (asynchronous). After rst=1 with buttons low, no strobes.
